// File: rtl/parallel2serial_pkg.sv
// Shared definitions for the parallel2serial / serial2parallel link:
// shifter state encoding, default word width and counter sizing.
package parallel2serial_pkg;

    localparam int P2S_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } p2s_state_e;

    // Bits needed to count 0..n-1, never less than one so that degenerate
    // counts (n = 1, e.g. GAP_CYCLES = 0) still produce a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parallel2serial_if.sv
// Parallel-in handshake plus serial-out bundle of the serializer.
// The master drives words in; the slave (the serializer) answers with ready and the serial stream.
interface parallel2serial_if #(
    parameter int WIDTH = parallel2serial_pkg::P2S_DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] din_parallel;
    logic             din_valid;
    logic             din_ready;
    logic             dout_serial;
    logic             dout_valid;
    logic             busy;

    modport master (
        output din_parallel,
        output din_valid,
        input  din_ready,
        input  dout_serial,
        input  dout_valid,
        input  busy
    );

    modport slave (
        input  din_parallel,
        input  din_valid,
        output din_ready,
        output dout_serial,
        output dout_valid,
        output busy
    );

endinterface

// File: rtl/p2s_hold_buf.sv
// One-entry holding register in front of the shifter. It owns din_ready and
// captures an accepted word unless the shifter takes that word directly.
module p2s_hold_buf #(
    parameter int WIDTH = parallel2serial_pkg::P2S_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_parallel_i,
    input  logic             din_valid_i,
    input  logic             load_hold_i,
    input  logic             bypass_i,
    output logic             din_ready_o,
    output logic             accept_o,
    output logic             hold_full_o,
    output logic [WIDTH-1:0] hold_data_o
);

    logic             hold_full_q;
    logic             hold_full_d;
    logic [WIDTH-1:0] hold_data_q;
    logic             capture;

    assign din_ready_o = rst_n & ~hold_full_q;
    assign accept_o    = din_valid_i & din_ready_o;
    assign capture     = accept_o & ~bypass_i;

    // A capture wins over a simultaneous drain so the newest word is kept.
    always_comb begin
        hold_full_d = hold_full_q;
        if (capture) begin
            hold_full_d = 1'b1;
        end else if (load_hold_i) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
        end
    end

    // NOTE: the data register is deliberately left out of reset; its contents
    // are only ever read while hold_full_q qualifies them.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_data_q <= din_parallel_i;
        end
    end

    assign hold_full_o = hold_full_q;
    assign hold_data_o = hold_data_q;

endmodule

// File: rtl/parallel2serial.sv
// Word serializer: takes WIDTH-bit words over valid/ready and shifts them out
// MSB first with a dout_valid qualifier and GAP_CYCLES idle cycles after each word.
module parallel2serial
    import parallel2serial_pkg::*;
#(
    parameter int WIDTH      = P2S_DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    parallel2serial_if.slave bus
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    p2s_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;

    logic             load;
    logic             load_hold;
    logic             bypass;
    logic             accept;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             word_avail;
    logic [WIDTH-1:0] next_word;

    p2s_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_parallel_i(bus.din_parallel),
        .din_valid_i   (bus.din_valid),
        .load_hold_i   (load_hold),
        .bypass_i      (bypass),
        .din_ready_o   (bus.din_ready),
        .accept_o      (accept),
        .hold_full_o   (hold_full),
        .hold_data_o   (hold_data)
    );

    // The held word is older than anything arriving now, so it loads first.
    assign word_avail = hold_full | accept;
    assign next_word  = hold_full ? hold_data : bus.din_parallel;
    assign load_hold  = load & hold_full;
    assign bypass     = load & ~hold_full;

    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load = word_avail;
            end

            ST_SHIFT: begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else if (word_avail) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    if (word_avail) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d   = ST_SHIFT;
            shreg_d   = next_word;
            bit_cnt_d = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign bus.dout_valid  = (state_q == ST_SHIFT);
    assign bus.dout_serial = (state_q == ST_SHIFT) & shreg_q[WIDTH-1];
    assign bus.busy        = (state_q != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_parallel2serial.sv
// Directed bench for parallel2serial: one instance with a one-cycle gap and one
// with back-to-back words, plus a bit-level deserializer model for loopback.
module tb_parallel2serial;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    parallel2serial_if #(.WIDTH(W)) b1 ();
    parallel2serial_if #(.WIDTH(W)) b0 ();

    parallel2serial #(.WIDTH(W), .GAP_CYCLES(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1)
    );

    parallel2serial #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receive-side model: gathers eight valid bits MSB first into a word.
    logic [W-1:0] q1[$];
    logic [W-1:0] m1_sh;
    int           m1_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m1_cnt = 0;
        end else if (b1.dout_valid) begin
            m1_sh = {m1_sh[W-2:0], b1.dout_serial};
            if (m1_cnt == W - 1) begin
                q1.push_back(m1_sh);
                m1_cnt = 0;
            end else begin
                m1_cnt++;
            end
        end
    end

    logic [9:0]   v10, d10, bz10;
    logic [17:0]  v18, d18;
    logic [25:0]  v26, d26;
    logic [W-1:0] words[3];
    logic [W-1:0] sent[$];
    logic         acc;
    int           idx;
    int           acc3;
    int           vcnt;

    initial begin
        rst_n           = 1'b0;
        b1.din_valid    = 1'b0;
        b1.din_parallel = '0;
        b0.din_valid    = 1'b0;
        b0.din_parallel = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_dout_valid", b1.dout_valid, 1'b0);
        check("rst_dout_serial", b1.dout_serial, 1'b0);
        check("rst_busy", b1.busy, 1'b0);
        check("rst_din_ready", b1.din_ready, 1'b0);
        check("rst_busy_gap0", b0.busy, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", b1.din_ready, 1'b1);
        @(negedge clk);

        // Single word A5: valid N+1..N+8, gap at N+9, idle from N+10
        q1.delete();
        b1.din_parallel = 8'hA5;
        b1.din_valid    = 1'b1;
        @(negedge clk);
        b1.din_valid    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            v10[9-c]  = b1.dout_valid;
            d10[9-c]  = b1.dout_serial;
            bz10[9-c] = b1.busy;
            @(negedge clk);
        end
        check("a5_valid_pattern", v10, 10'b11111111_00);
        check("a5_bit_stream", d10, 10'b10100101_00);
        check("a5_busy_pattern", bz10, 10'b11111111_10);
        check("a5_rx_count", q1.size(), 1);
        check("a5_rx_word", q1[0], 8'hA5);

        // Back-to-back F0, 3C with one gap cycle between them
        q1.delete();
        b1.din_parallel = 8'hF0;
        b1.din_valid    = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 18; c++) begin
            v18[17-c] = b1.dout_valid;
            d18[17-c] = b1.dout_serial;
            if (c == 0) begin
                check("b2b_ready_hold_empty", b1.din_ready, 1'b1);
                b1.din_parallel = 8'h3C;
            end
            if (c == 1) begin
                check("b2b_ready_hold_full", b1.din_ready, 1'b0);
                check("b2b_busy", b1.busy, 1'b1);
                b1.din_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_valid_pattern", v18, 18'b11111111_0_11111111_0);
        check("b2b_bit_stream", d18, 18'b11110000_0_00111100_0);
        check("b2b_idle_busy", b1.busy, 1'b0);
        check("b2b_rx_count", q1.size(), 2);
        check("b2b_rx_order", {q1[0], q1[1]}, 16'hF03C);

        // Zero-gap instance: 01, 80, FF streamed with no bubble
        words = '{8'h01, 8'h80, 8'hFF};
        idx   = 0;
        b0.din_parallel = words[0];
        b0.din_valid    = 1'b1;
        acc = b0.din_valid & b0.din_ready;
        @(negedge clk);
        for (int c = 0; c < 26; c++) begin
            if (acc) idx++;
            v26[25-c] = b0.dout_valid;
            d26[25-c] = b0.dout_serial;
            if (idx < 3) begin
                b0.din_parallel = words[idx];
                b0.din_valid    = 1'b1;
            end else begin
                b0.din_valid = 1'b0;
            end
            if (c == 4) check("gap0_ready_while_held", b0.din_ready, 1'b0);
            acc = b0.din_valid & b0.din_ready;
            @(negedge clk);
        end
        check("gap0_valid_pattern", v26, 26'b11111111_11111111_11111111_00);
        check("gap0_bit_stream", d26, 26'b00000001_10000000_11111111_00);
        check("gap0_all_accepted", idx, 3);
        check("gap0_idle_busy", b0.busy, 1'b0);

        // Backpressure: third word must wait until the held word loads
        q1.delete();
        words = '{8'h11, 8'h22, 8'h33};
        idx   = 0;
        acc   = 1'b0;
        acc3  = -1;
        for (int c = 0; c < 32; c++) begin
            if (acc) idx++;
            if (idx < 3) begin
                b1.din_parallel = words[idx];
                b1.din_valid    = 1'b1;
            end else begin
                b1.din_valid = 1'b0;
            end
            if (c == 5)  check("bp_ready_c5", b1.din_ready, 1'b0);
            if (c == 9)  check("bp_ready_c9", b1.din_ready, 1'b0);
            if (c == 10) check("bp_ready_c10", b1.din_ready, 1'b1);
            acc = b1.din_valid & b1.din_ready;
            if (acc && idx == 2) acc3 = c;
            @(negedge clk);
        end
        check("bp_third_accept_cycle", acc3, 10);
        check("bp_accept_total", idx, 3);
        check("bp_rx_count", q1.size(), 3);
        check("bp_rx_order", {q1[0], q1[1], q1[2]}, 24'h112233);
        check("bp_idle_busy", b1.busy, 1'b0);

        // Reset at bit 4 of C3 with 5A held: both words dropped
        q1.delete();
        b1.din_parallel = 8'hC3;
        b1.din_valid    = 1'b1;
        @(negedge clk);
        b1.din_parallel = 8'h5A;
        @(negedge clk);
        b1.din_valid = 1'b0;
        check("rstmid_hold_full_ready", b1.din_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("rstmid_bit4_valid", b1.dout_valid, 1'b1);
        check("rstmid_bit4_value", b1.dout_serial, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_valid", b1.dout_valid, 1'b0);
        check("rstmid_serial", b1.dout_serial, 1'b0);
        check("rstmid_busy", b1.busy, 1'b0);
        check("rstmid_ready_in_reset", b1.din_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_ready_after", b1.din_ready, 1'b1);
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b1.dout_valid) vcnt++;
        end
        check("rstmid_no_tx_bits", vcnt, 0);
        check("rstmid_no_rx_words", q1.size(), 0);

        // Loopback with random words and random valid gaps
        q1.delete();
        sent.delete();
        acc = 1'b0;
        for (int c = 0; c < 3000 && sent.size() < 16; c++) begin
            if (acc) begin
                sent.push_back(b1.din_parallel);
                b1.din_valid = 1'b0;
            end
            if (!b1.din_valid && sent.size() < 16 && $urandom_range(0, 2) != 0) begin
                b1.din_parallel = 8'($urandom);
                b1.din_valid    = 1'b1;
            end
            acc = b1.din_valid & b1.din_ready;
            @(negedge clk);
        end
        b1.din_valid = 1'b0;
        for (int c = 0; c < 100 && b1.busy; c++) @(negedge clk);
        check("lb_words_sent", sent.size(), 16);
        check("lb_drained", b1.busy, 1'b0);
        check("lb_rx_count", q1.size(), sent.size());
        foreach (sent[i]) begin
            if (i < q1.size()) check($sformatf("lb_word%0d", i), q1[i], sent[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
